// File: rtl/risc_pkg.sv
// -----------------------------------------------------------------------------
// risc_pkg
// Shared definitions for the RISC core slice:
//   - default datapath widths (memory byte, operand/PC address, opcode)
//   - opcode encodings
//   - instruction fetch FSM state encoding and a state-class helper
// No ports (package).
// -----------------------------------------------------------------------------
package risc_pkg;

    localparam int unsigned DEF_DATA_W         = 8;
    localparam int unsigned DEF_ADDR_W         = 13;
    localparam int unsigned DEF_OPC_W          = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef logic [3:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE   = 4'd0;
    localparam fetch_state_t ST_RD_HI  = 4'd1;
    localparam fetch_state_t ST_INC_HI = 4'd2;
    localparam fetch_state_t ST_RD_LO  = 4'd3;
    localparam fetch_state_t ST_INC_LO = 4'd4;
    localparam fetch_state_t ST_VALID  = 4'd5;
    localparam fetch_state_t ST_LD_SET = 4'd6;
    localparam fetch_state_t ST_LD_P   = 4'd7;
    localparam fetch_state_t ST_SK_P   = 4'd8;
    localparam fetch_state_t ST_SK_G   = 4'd9;

    // States in which a memory read is outstanding.
    function automatic logic is_rd_state(input fetch_state_t s);
        return (s == ST_RD_HI) || (s == ST_RD_LO);
    endfunction

    // States that pulse the PC advance strobe.
    function automatic logic is_incr_state(input fetch_state_t s);
        return (s == ST_INC_HI) || (s == ST_INC_LO) || (s == ST_LD_P) || (s == ST_SK_P);
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// -----------------------------------------------------------------------------
// fetch_wdog
// Counts consecutive cycles spent waiting on a memory read and flags when the
// last permitted cycle is reached without the wait being cleared.
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clr      in   restart the count (takes priority over en)
//   en       in   a read is outstanding this cycle
//   expired  out  this is the TIMEOUT_CYCLES-th waiting cycle
// -----------------------------------------------------------------------------
module fetch_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ir_fetch.sv
// -----------------------------------------------------------------------------
// ir_fetch
// Instruction fetch sequencer upstream of the program counter. Reads each
// instruction as two bytes (high first) at the PC, strobes the PC after each
// byte, holds the assembled instruction for the controller, and performs PC
// loads (jmp) and two-step skips (skip) on the controller's handshake.
// Optional feature: define FETCH_TIMEOUT_EN to add a read timeout watchdog
// with a sticky fetch_err flag; otherwise reads wait on mem_ack forever.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_en              controller permits the next fetch
//   mem_rd / mem_ack      memory read request (held) / data valid
//   mem_data              memory read byte
//   incr_pc / load_pc     PC advance strobe / PC load select
//   ir_opcode / ir_addr   held instruction fields (ir_addr is the load value)
//   ir_valid / ir_ready   instruction handshake
//   jmp / skip            action requested with the handshake (jmp wins)
//   fetch_err             sticky read timeout flag
// -----------------------------------------------------------------------------
module ir_fetch
    import risc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned OPC_W  = DEF_OPC_W
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              incr_pc,
    output logic              load_pc,
    output logic [OPC_W-1:0]  ir_opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              jmp,
    input  logic              skip,
    output logic              fetch_err
);

    localparam int unsigned IR_W = 2 * DATA_W;
    localparam logic [1:0]  SKIP_STEPS = 2'd2;

    fetch_state_t      state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [1:0]        skip_cnt_q, skip_cnt_d;
    logic              timeout;
    logic              fetch_blocked;

`ifdef FETCH_TIMEOUT_EN
    logic rd_active;
    logic wdog_clr;
    logic wdog_expired;
    logic err_q;

    assign rd_active = is_rd_state(state_q);
    // Any non-read state or an ack restarts the wait count.
    assign wdog_clr  = !rd_active || mem_ack;

    fetch_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdog_clr),
        .en      (rd_active),
        .expired (wdog_expired)
    );

    // An ack on the last permitted cycle still completes the read.
    assign timeout = wdog_expired && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err     = err_q;
    assign fetch_blocked = err_q;
`else
    assign timeout       = 1'b0;
    assign fetch_blocked = 1'b0;
    assign fetch_err     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        skip_cnt_d = skip_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fetch_en && !fetch_blocked) state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
                if (mem_ack) begin
                    ir_d[IR_W-1:DATA_W] = mem_data;
                    state_d             = ST_INC_HI;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_INC_HI: state_d = ST_RD_LO;
            ST_RD_LO: begin
                if (mem_ack) begin
                    ir_d[DATA_W-1:0] = mem_data;
                    state_d          = ST_INC_LO;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_INC_LO: state_d = ST_VALID;
            ST_VALID: begin
                if (ir_ready) begin
                    if (jmp) begin
                        state_d = ST_LD_SET;
                    end else if (skip) begin
                        state_d    = ST_SK_P;
                        skip_cnt_d = SKIP_STEPS;
                    end else begin
                        state_d = fetch_en ? ST_RD_HI : ST_IDLE;
                    end
                end
            end
            // load_pc leads incr_pc by one cycle so the PC mux settles first.
            ST_LD_SET: state_d = ST_LD_P;
            ST_LD_P:   state_d = ST_IDLE;
            ST_SK_P: begin
                skip_cnt_d = skip_cnt_q - 1'b1;
                state_d    = ST_SK_G;
            end
            // Gap cycle keeps incr_pc pulses separated.
            ST_SK_G: state_d = (skip_cnt_q != 2'd0) ? ST_SK_P : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            skip_cnt_q <= 2'd0;
            mem_rd     <= 1'b0;
            incr_pc    <= 1'b0;
            load_pc    <= 1'b0;
            ir_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            skip_cnt_q <= skip_cnt_d;
            mem_rd     <= is_rd_state(state_d);
            incr_pc    <= is_incr_state(state_d);
            load_pc    <= (state_d == ST_LD_SET) || (state_d == ST_LD_P);
            ir_valid   <= (state_d == ST_VALID);
        end
    end

    assign ir_opcode = ir_q[IR_W-1 -: OPC_W];
    assign ir_addr   = ir_q[ADDR_W-1:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Scoreboard bench for ir_fetch: a byte memory and PC model surround the DUT;
// each fetch pushes its expected instruction, arrival cycle and PC, and a
// monitor pops and compares when ir_valid rises.
module tb_ir_fetch;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        incr_pc;
    logic        load_pc;
    logic [2:0]  ir_opcode;
    logic [12:0] ir_addr;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        jmp = 1'b0;
    logic        skip = 1'b0;
    logic        fetch_err;

    always #5 clk = ~clk;

    ir_fetch u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_en  (fetch_en),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .incr_pc   (incr_pc),
        .load_pc   (load_pc),
        .ir_opcode (ir_opcode),
        .ir_addr   (ir_addr),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .jmp       (jmp),
        .skip      (skip),
        .fetch_err (fetch_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [2:0]  opc;
        logic [12:0] addr;
        int          at_cyc;
        logic [12:0] pc;
    } exp_t;
    exp_t sbq[$];

    logic [7:0]  mem [0:8191];
    logic [12:0] pc;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic        stray = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // PC model: load on incr_pc when load_pc is set, else advance.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 13'h0000;
        else if (incr_pc) pc <= load_pc ? ir_addr : pc + 13'h0001;
    end

    // Memory model: acks after ack_delay waiting cycles; stray drives a bogus ack.
    always begin
        @(negedge clk);
        #1;
        if (mem_rd) begin
            if (wcnt == ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem[pc];
                wcnt     = 0;
            end else begin
                mem_ack  = 1'b0;
                mem_data = 8'h00;
                wcnt++;
            end
        end else begin
            mem_ack  = stray;
            mem_data = stray ? 8'hFF : 8'h00;
            wcnt     = 0;
        end
    end

    // Monitor: scoreboard pops plus strobe-rule checks.
    logic prev_rst = 1'b0, prev_valid = 1'b0, prev_incr = 1'b0, prev_load = 1'b0;
    logic prev_mem_rd = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            if (ir_valid && !prev_valid) begin
                check("sb_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ir_opcode", 32'(ir_opcode), 32'(e.opc));
                    check("ir_addr", 32'(ir_addr), 32'(e.addr));
                    check("valid_cycle", 32'(cyc), 32'(e.at_cyc));
                    check("pc_at_valid", 32'(pc), 32'(e.pc));
                end
            end
            if (incr_pc) begin
                check("incr_gap", 32'(prev_incr), 32'd0);
                if (load_pc) check("load_setup", 32'(prev_load), 32'd1);
            end
            if (prev_mem_rd && !mem_ack && !fetch_err) check("mem_rd_hold", 32'(mem_rd), 32'd1);
        end
        prev_rst    = rst_n;
        prev_valid  = ir_valid;
        prev_incr   = incr_pc;
        prev_load   = load_pc;
        prev_mem_rd = mem_rd;
    end

    task automatic fetch(input int delay, input logic [2:0] opc, input logic [12:0] addr,
                         input int lat, input logic [12:0] exp_pc);
        ack_delay = delay;
        @(negedge clk);
        fetch_en = 1'b1;
        sbq.push_back('{opc: opc, addr: addr, at_cyc: cyc + lat, pc: exp_pc});
        @(negedge clk);
        fetch_en = 1'b0;
        for (int i = 0; i < 40 && !ir_valid; i++) @(negedge clk);
        check("fetch_done", 32'(ir_valid), 32'd1);
    endtask

    task automatic handshake(input logic j, input logic s);
        ir_ready = 1'b1;
        jmp      = j;
        skip     = s;
        @(negedge clk);
        ir_ready = 1'b0;
        jmp      = 1'b0;
        skip     = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_incr_pc"}, 32'(incr_pc), 32'd0);
        check({tag, "_load_pc"}, 32'(load_pc), 32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    endtask

    task automatic jmp_sequence(input logic [12:0] target);
        check("ld_set_load", 32'(load_pc), 32'd1);
        check("ld_set_incr", 32'(incr_pc), 32'd0);
        @(negedge clk);
        check("ld_p_load", 32'(load_pc), 32'd1);
        check("ld_p_incr", 32'(incr_pc), 32'd1);
        @(negedge clk);
        check("ld_done_load", 32'(load_pc), 32'd0);
        check("ld_done_incr", 32'(incr_pc), 32'd0);
        check("pc_after_jmp", 32'(pc), 32'(target));
    endtask

    initial begin
        logic [3:0] sk_pat;
        int         s;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] sk_pat;
        int         s;
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[0]       = 8'hE0;
        mem[1]       = 8'h12;
        mem[4]       = 8'hE0;
        mem[5]       = 8'h12;
        mem[13'h12]  = 8'h3A;
        mem[13'h13]  = 8'hBC;
        mem[13'h1ABC] = 8'h55;

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_ir_opcode", 32'(ir_opcode), 32'd0);
        check("reset_ir_addr", 32'(ir_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_rd", 32'(mem_rd), 32'd0);

        // Zero-wait fetch: E0 12, valid 5 clks after fetch_en sampled, PC 0 -> 2
        fetch(0, OP_JMP, 13'h0012, 5, 13'h0002);

        // Stray ack in VALID must not disturb ir
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_opcode", 32'(ir_opcode), 32'd7);
        check("stray_addr", 32'(ir_addr), 32'h0012);
        check("stray_valid", 32'(ir_valid), 32'd1);

        // Skip: incr pattern 1,0,1,0 then PC 2 -> 4
        handshake(1'b0, 1'b1);
        sk_pat[3] = incr_pc;
        @(negedge clk); sk_pat[2] = incr_pc;
        @(negedge clk); sk_pat[1] = incr_pc;
        @(negedge clk); sk_pat[0] = incr_pc;
        check("skip_incr_pattern", 32'(sk_pat), 32'b1010);
        @(negedge clk);
        check("pc_after_skip", 32'(pc), 32'h0004);
        check("skip_no_load", 32'(load_pc), 32'd0);
        check("skip_valid_low", 32'(ir_valid), 32'd0);

        // Three wait cycles per byte: valid after 11 clks, PC 4 -> 6
        fetch(3, OP_JMP, 13'h0012, 11, 13'h0006);

        // Jump to 0x0012
        handshake(1'b1, 1'b0);
        jmp_sequence(13'h0012);

        // Fetch 3A BC at 0x12, then jmp+skip together loads only
        fetch(0, OP_SKZ, 13'h1ABC, 5, 13'h0014);
        handshake(1'b1, 1'b1);
        jmp_sequence(13'h1ABC);

        // Reset during RD_LO after the high-byte ack
        ack_delay = 2;
        @(negedge clk);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        for (int i = 0; i < 20 && !incr_pc; i++) @(negedge clk);
        check("abort_saw_inc_hi", 32'(incr_pc), 32'd1);
        @(negedge clk);
        check("abort_in_rd_lo", 32'(mem_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_no_incr", 32'(incr_pc), 32'd0);
        end
        check("post_reset_pc", 32'(pc), 32'd0);
        fetch(0, OP_JMP, 13'h0012, 5, 13'h0002);

        // Plain accept with fetch_en low returns to idle
        handshake(1'b0, 1'b0);
        check("accept_valid_low", 32'(ir_valid), 32'd0);
        check("accept_no_rd", 32'(mem_rd), 32'd0);
        check("no_fetch_err", 32'(fetch_err), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // Memory never acks: error after 16 read cycles, then fetch_en ignored
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 100000;
        @(negedge clk);
        fetch_en = 1'b1;
        s = cyc;
        while (cyc < s + 16) @(negedge clk);
        check("to_before_err", 32'(fetch_err), 32'd0);
        check("to_before_rd", 32'(mem_rd), 32'd1);
        @(negedge clk);
        check("to_err_set", 32'(fetch_err), 32'd1);
        check("to_rd_drop", 32'(mem_rd), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_blocked_rd", 32'(mem_rd), 32'd0);
        end
        fetch_en = 1'b0;
        check("to_pc_unmoved", 32'(pc), 32'd0);
        check("to_err_sticky", 32'(fetch_err), 32'd1);
        rst_n = 1'b0;
        #1 check("to_err_cleared", 32'(fetch_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
